// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream input and imem write-port bundle for the boot loader.
// master = byte source / imem side, slave = loader.
interface boot_loader_ctrl_if;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        imem_we;
   logic [31:0] imem_wa;
   logic [31:0] imem_wd;

   modport master (
      output s_valid, s_data,
      input  s_ready, imem_we, imem_wa, imem_wd
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, imem_we, imem_wa, imem_wd
   );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot loader: holds the core in reset, loads a framed little-endian word stream
// into imem from address 0, verifies an 8-bit checksum, then releases the core.
module boot_loader_ctrl #(
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_req,
   boot_loader_ctrl_if.slave         bus,
   output logic                      core_reset,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t           state, state_nx;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] n_words;
   logic [7:0]       cnt_lo;
   logic [7:0]       csum;
   logic [23:0]      word_buf;
   logic [16:0]      n_frame;
   logic             accept;
   logic             last_word;
   logic             core_reset_nx, busy_nx, done_nx, err_nx;

   assign n_frame   = {1'b0, bus.s_data, cnt_lo};
   assign accept    = bus.s_valid && bus.s_ready;
   assign last_word = (idx == n_words - CNT_W'(1));

   // State register; status flags are registered from the next state so they
   // change on the same edge as the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LEN0;
         core_reset <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         core_reset <= core_reset_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         err        <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (load_req) begin
         state_nx = LEN0;
      end else if (accept) begin
         unique case (state)
            LEN0: state_nx = LEN1;
            LEN1: begin
               if (n_frame == 17'd0)
                  state_nx = CSUM;
               else if (n_frame > MAX_N)
                  state_nx = ERR;
               else
                  state_nx = DATA;
            end
            DATA: if (byte_cnt == 2'd3 && last_word) state_nx = CSUM;
            CSUM: state_nx = (bus.s_data == csum) ? RUN : ERR;
            default: state_nx = state;
         endcase
      end
   end

   always_comb begin
      bus.s_ready   = 1'b0;
      if ((state == LEN0 || state == LEN1 || state == DATA || state == CSUM)
          && !load_req && !reset)
         bus.s_ready = 1'b1;
      core_reset_nx = (state_nx != RUN);
      busy_nx       = (state_nx == LEN1 || state_nx == DATA || state_nx == CSUM);
      done_nx       = (state_nx == RUN);
      err_nx        = (state_nx == ERR);
   end

   // Datapath: byte assembly, word index, checksum and the imem write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt    <= '0;
         idx         <= '0;
         n_words     <= '0;
         cnt_lo      <= '0;
         csum        <= '0;
         word_buf    <= '0;
         bus.imem_we <= 1'b0;
         bus.imem_wa <= '0;
         bus.imem_wd <= '0;
      end else if (load_req) begin
         byte_cnt    <= '0;
         idx         <= '0;
         csum        <= '0;
         bus.imem_we <= 1'b0;
      end else begin
         bus.imem_we <= 1'b0;
         if (accept) begin
            csum <= csum + bus.s_data;
            unique case (state)
               LEN0: cnt_lo  <= bus.s_data;
               LEN1: n_words <= CNT_W'(n_frame[15:0]);
               DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;
                  unique case (byte_cnt)
                     2'd0: word_buf[7:0]   <= bus.s_data;
                     2'd1: word_buf[15:8]  <= bus.s_data;
                     2'd2: word_buf[23:16] <= bus.s_data;
                     default: begin
                        bus.imem_we <= 1'b1;
                        bus.imem_wa <= 32'({idx, 2'b00});
                        bus.imem_wd <= {bus.s_data, word_buf};
                        idx         <= idx + CNT_W'(1);
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: frame model pushes expected imem writes,
// the per-cycle sampler pops and compares them.
module tb_boot_loader_ctrl;

   logic clk = 1'b0;
   logic reset, load_req;
   logic core_reset, busy, done, err;

   boot_loader_ctrl_if bus ();

   boot_loader_ctrl #(.MAX_WORDS(256), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_req   (load_req),
      .bus        (bus.slave),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] sb[$];

   int          m_idx;
   logic [15:0] m_n;
   logic [31:0] m_word;
   int          m_widx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx  = 0;
      m_n    = '0;
      m_word = '0;
      m_widx = 0;
   endtask

   // Frame model: one call per byte the DUT accepts.
   task automatic model_byte(input logic [7:0] b);
      int k;
      if (m_idx == 0) m_n[7:0] = b;
      else if (m_idx == 1) m_n[15:8] = b;
      else if (m_n <= 16'd256 && (m_idx - 2) < 4 * int'(m_n)) begin
         k = (m_idx - 2) % 4;
         m_word[8*k +: 8] = b;
         if (k == 3) begin
            sb.push_back({32'(m_widx * 4), m_word});
            m_widx++;
         end
      end
      m_idx++;
   endtask

   task automatic tick();
      logic [63:0] e;
      @(posedge clk);
      #1;
      if (bus.imem_we === 1'b1) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL spurious_write: observed wa=0x%0h wd=0x%0h expected=no write",
                   bus.imem_wa, bus.imem_wd);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imem_wa", bus.imem_wa, e[63:32]);
            chk("imem_wd", bus.imem_wd, e[31:0]);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) begin
         bus.s_valid = 1'b0;
         tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      #1;
      for (int g = 0; g < 20 && bus.s_ready !== 1'b1; g++) tick();
      chk("s_ready_wait", 32'(bus.s_ready), 1);
      if (bus.s_ready === 1'b1) begin
         model_byte(b);
         tick();
      end
   endtask

   task automatic pulse_load();
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      load_req    = 1'b1;
      #1;
      chk("ready_during_load_req", 32'(bus.s_ready), 0);
      tick();
      load_req    = 1'b0;
      bus.s_valid = 1'b0;
      model_reset();
      #1;
      chk("ld_core_reset", 32'(core_reset), 1);
      chk("ld_done", 32'(done), 0);
      chk("ld_err", 32'(err), 0);
      chk("ld_busy", 32'(busy), 0);
      chk("ld_s_ready", 32'(bus.s_ready), 1);
   endtask

   logic [7:0] f1[11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};

   initial begin
      reset       = 1'b1;
      load_req    = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      model_reset();
      tick();
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_imem_we", 32'(bus.imem_we), 0);
      chk("rst_imem_wa", bus.imem_wa, 0);
      chk("rst_imem_wd", bus.imem_wd, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_s_ready", 32'(bus.s_ready), 0);
      reset = 1'b0;
      #1;
      chk("len0_s_ready", 32'(bus.s_ready), 1);

      // Test 1: two-word frame, good checksum
      for (int i = 0; i < 10; i++) send_byte(f1[i], 0);
      chk("t1_core_reset_pre", 32'(core_reset), 1);
      chk("t1_busy_pre", 32'(busy), 1);
      send_byte(f1[10], 0);
      bus.s_valid = 1'b0;
      chk("t1_core_reset", 32'(core_reset), 0);
      chk("t1_done", 32'(done), 1);
      chk("t1_err", 32'(err), 0);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_s_ready", 32'(bus.s_ready), 0);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // Test 2: bad checksum
      pulse_load();
      for (int i = 0; i < 10; i++) send_byte(f1[i], 0);
      send_byte(8'hB9, 0);
      chk("t2_err", 32'(err), 1);
      chk("t2_done", 32'(done), 0);
      chk("t2_core_reset", 32'(core_reset), 1);
      chk("t2_s_ready", 32'(bus.s_ready), 0);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h55;
      for (int i = 0; i < 4; i++) tick();
      chk("t2_s_ready_hold", 32'(bus.s_ready), 0);
      chk("t2_err_hold", 32'(err), 1);
      bus.s_valid = 1'b0;
      chk("t2_sb_empty", 32'(sb.size()), 0);

      // Test 3: empty frame
      pulse_load();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      bus.s_valid = 1'b0;
      chk("t3_done", 32'(done), 1);
      chk("t3_core_reset", 32'(core_reset), 0);
      chk("t3_err", 32'(err), 0);

      // Test 4: N = 257 is oversize
      pulse_load();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      bus.s_valid = 1'b0;
      chk("t4_err", 32'(err), 1);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_s_ready", 32'(bus.s_ready), 0);
      tick();
      tick();
      chk("t4_sb_empty", 32'(sb.size()), 0);

      // Test 5: test-1 frame with random idle gaps
      pulse_load();
      for (int i = 0; i < 11; i++) send_byte(f1[i], int'($urandom_range(0, 5)));
      bus.s_valid = 1'b0;
      chk("t5_done", 32'(done), 1);
      chk("t5_err", 32'(err), 0);
      chk("t5_sb_empty", 32'(sb.size()), 0);

      // Test 6: abort after 5 data bytes, reload, then abort from RUN
      pulse_load();
      for (int i = 0; i < 7; i++) send_byte(f1[i], 0);
      pulse_load();
      for (int i = 0; i < 4; i++) tick();
      chk("t6_partial_dropped", 32'(sb.size()), 0);
      for (int i = 0; i < 11; i++) send_byte(f1[i], 0);
      bus.s_valid = 1'b0;
      chk("t6_done", 32'(done), 1);
      chk("t6_core_reset", 32'(core_reset), 0);
      chk("t6_sb_empty", 32'(sb.size()), 0);
      pulse_load();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
